pipe_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 6 +
 rtl/reg_scoreboard.sv | 36 +++
 rtl/pipe_ctrl.sv | 57 +++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state type and constants for the pipeline sequencer
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, CTRL_WAIT, HALT_DRAIN, HALTED} pc_state_t;
  localparam logic [3:0] REG_ZERO = 4'd0;
  localparam int DEF_WB_LAT = 3;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write countdown (clk, rst, wr_en/wr_addr load, rd_a/rd_b lookups -> busy_a/busy_b, busy vector)
module reg_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int WB_LAT = DEF_WB_LAT,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CNT_W = $clog2(WB_LAT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [AW-1:0]       rd_a,
  input  logic [AW-1:0]       rd_b,
  output logic                busy_a,
  output logic                busy_b,
  output logic [NUM_REGS-1:0] busy
);
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic load_ok;
  assign load_ok = wr_en && wr_addr != AW'(REG_ZERO);
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    if (g == 0) begin : g_zero
      assign cnt[g] = '0;
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst)
        if (rst) cnt[g] <= '0;
        else if (load_ok && wr_addr == AW'(g)) cnt[g] <= CNT_W'(WB_LAT);
        else if (cnt[g] != '0) cnt[g] <= cnt[g] - CNT_W'(1);
    end
    assign busy[g] = cnt[g] != '0;
  end
  assign busy_a = busy[rd_a];
  assign busy_b = busy[rd_b];
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: WISC-S15 pipeline sequencer (id_* decode inputs, pc_update -> pc_hold, if_id_hold, if_id_flush, id_ex_bubble, sb_busy, halted)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int WB_LAT = DEF_WB_LAT,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       id_rs,
  input  logic [AW-1:0]       id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_reg_write,
  input  logic                id_ctrl,
  input  logic                id_halt,
  input  logic                pc_update,
  output logic                pc_hold,
  output logic                if_id_hold,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic                halted
);
  pc_state_t state;
  logic busy_rs, busy_rt, haz, fire, run;
  reg_scoreboard #(.NUM_REGS(NUM_REGS), .WB_LAT(WB_LAT)) u_sb (
    .clk(clk),
    .rst(rst),
    .wr_en(fire & id_reg_write),
    .wr_addr(id_rd),
    .rd_a(id_rs),
    .rd_b(id_rt),
    .busy_a(busy_rs),
    .busy_b(busy_rt),
    .busy(sb_busy)
  );
  assign run = state == RUN;
  assign haz = (id_rs_used & busy_rs) | (id_rt_used & busy_rt);
  assign fire = id_valid & run & ~haz;
  always_comb begin
    pc_hold = run ? id_valid & haz : state == CTRL_WAIT ? ~pc_update : 1'b1;
    if_id_hold = run & id_valid & haz;
    if_id_flush = ~run;
    id_ex_bubble = ~fire;
    halted = state == HALTED;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= run ? (fire & id_halt ? HALT_DRAIN : fire & id_ctrl ? CTRL_WAIT : RUN)
                : state == CTRL_WAIT ? (pc_update ? RUN : CTRL_WAIT)
                : state == HALT_DRAIN ? (|sb_busy ? HALT_DRAIN : HALTED)
                : HALTED;
endmodule
